systolic_feeder: RTL and testbench

- Produces the skewed operand streams and the i_doProcess strobe that drive the N x N systolic array multiplier.
- Accepts two complete signed 8-bit NxN matrices A and B through a start/ready handshake and latches them.
- Emits one diagonal "wavefront" per cycle: A rows to the west-edge PE inputs, B columns to the north-edge PE inputs.
- Pulses o_done when every PE accumulator holds its final dot product.

---
 rtl/systolic_feeder.sv | 126 ++++++++++++
 tb/tb_systolic_feeder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// systolic_feeder: latches two NxN signed 8-bit matrices on a start handshake
// and streams them as skewed diagonal wavefronts into the west (A rows) and
// north (B columns) edges of an NxN systolic array, with an advance strobe
// and a one-cycle done pulse once every PE holds its final dot product.
module systolic_feeder #(
  parameter int N = 4
) (
  input  logic                            i_clk,
  input  logic                            i_arst,
  input  logic                            i_start,
  input  logic signed [N-1:0][N-1:0][7:0] i_a,
  input  logic signed [N-1:0][N-1:0][7:0] i_b,
  output logic                            o_ready,
  output logic                            o_doProcess,
  output logic signed [N-1:0][7:0]        o_row,
  output logic signed [N-1:0][7:0]        o_col,
  output logic                            o_busy,
  output logic                            o_done
);

  localparam int TW = $clog2(3*N-1);
  localparam logic [TW-1:0] T_LAST = TW'(3*N-3);

  typedef enum logic [1:0] {IDLE, FEED, DONE} state_e;

  state_e                   state_q, state_d;
  logic [TW-1:0]            t_q, t_d, wave_t;
  logic [N-1:0][N-1:0][7:0] a_q, a_d, b_q, b_d, a_src, b_src;
  logic [N-1:0][7:0]        row_q, row_d, col_q, col_d, row_w, col_w;
  logic                     dp_q, dp_d;

  // Wavefront for the cycle about to be presented. On the accepting edge the
  // matrices are not latched yet, so the live inputs are used with t = 0.
  always_comb begin
    a_src  = (state_q == IDLE) ? i_a : a_q;
    b_src  = (state_q == IDLE) ? i_b : b_q;
    wave_t = (state_q == IDLE) ? '0 : t_q + 1'b1;
    row_w  = '0;
    col_w  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (32'(wave_t) == i + k) begin
          row_w[i] = a_src[i][k];
          col_w[i] = b_src[k][i];
        end
      end
    end
  end

  // Next-state and registered-output update logic.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    a_d     = a_q;
    b_d     = b_q;
    row_d   = row_q;
    col_d   = col_q;
    dp_d    = dp_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = FEED;
          t_d     = '0;
          a_d     = i_a;
          b_d     = i_b;
          row_d   = row_w;
          col_d   = col_w;
          dp_d    = 1'b1;
        end
      end
      FEED: begin
        if (t_q == T_LAST) begin
          state_d = DONE;
          t_d     = '0;
          row_d   = '0;
          col_d   = '0;
          dp_d    = 1'b0;
        end else begin
          t_d   = t_q + 1'b1;
          row_d = row_w;
          col_d = col_w;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        t_d     = '0;
        row_d   = '0;
        col_d   = '0;
        dp_d    = 1'b0;
      end
    endcase
  end

  // State, counter, latched matrices and output registers.
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state_q <= IDLE;
      t_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      dp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      a_q     <= a_d;
      b_q     <= b_d;
      row_q   <= row_d;
      col_q   <= col_d;
      dp_q    <= dp_d;
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    o_ready     = (state_q == IDLE);
    o_busy      = (state_q == FEED);
    o_done      = (state_q == DONE);
    o_doProcess = dp_q;
    o_row       = row_q;
    o_col       = col_q;
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (N = 4) with a behavioural systolic array
// fed by the DUT outputs so end results can be checked as matrix products.
`timescale 1ns/1ps
module tb_systolic_feeder;
  localparam int N = 4;
  typedef logic [N-1:0][N-1:0][7:0] mat_t;
  typedef logic [N-1:0][7:0]        vec_t;

  logic clk = 1'b0;
  logic arst, start;
  mat_t a, b;
  logic ready, dp, busy, done;
  vec_t row, col;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  systolic_feeder #(.N(N)) dut (
    .i_clk(clk), .i_arst(arst), .i_start(start), .i_a(a), .i_b(b),
    .o_ready(ready), .o_doProcess(dp), .o_row(row), .o_col(col),
    .o_busy(busy), .o_done(done)
  );

  // Behavioural output-stationary array: A moves east, B moves south.
  int acc[N][N];
  logic signed [7:0] ah[N][N];
  logic signed [7:0] bv[N][N];
  always @(posedge clk) begin
    logic signed [7:0] ain, bin;
    if (ready && start && arst) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j] <= 0; ah[i][j] <= '0; bv[i][j] <= '0;
        end
    end else if (dp) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          if (j == 0) ain = $signed(row[i]); else ain = ah[i][j-1];
          if (i == 0) bin = $signed(col[j]); else bin = bv[i-1][j];
          ah[i][j]  <= ain;
          bv[i][j]  <= bin;
          acc[i][j] <= acc[i][j] + int'(ain) * int'(bin);
        end
    end
  end

  function automatic vec_t exp_row(mat_t m, int t);
    vec_t r = '0;
    for (int i = 0; i < N; i++) begin
      int k = t - i;
      if (k >= 0 && k < N) r[i] = m[i][k];
    end
    return r;
  endfunction

  function automatic vec_t exp_col(mat_t m, int t);
    vec_t r = '0;
    for (int j = 0; j < N; j++) begin
      int k = t - j;
      if (k >= 0 && k < N) r[j] = m[k][j];
    end
    return r;
  endfunction

  function automatic int exp_c(mat_t x, mat_t y, int i, int j);
    int s = 0;
    for (int k = 0; k < N; k++) s += int'($signed(x[i][k])) * int'($signed(y[k][j]));
    return s;
  endfunction

  task automatic test_reset;
    arst = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b exp 1", ready); end
    total++; if ({dp, busy, done} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b exp 000", {dp, busy, done}); end
    total++; if (row !== '0) begin bad++; $display("FAIL reset_row: got %h exp 0", row); end
    total++; if (col !== '0) begin bad++; $display("FAIL reset_col: got %h exp 0", col); end
    arst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_identity;
    int dpcount = 0;
    for (int r = 0; r < N; r++)
      for (int k = 0; k < N; k++) begin
        a[r][k] = (r == k) ? 8'd1 : 8'd0;
        b[r][k] = 8'(4*r + k + 1);
      end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL id_ready: got %b exp 1", ready); end
    start = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (dp === 1'b1) dpcount++;
      total++; if (done !== (cyc == 11)) begin bad++; $display("FAIL id_done cyc%0d: got %b exp %b", cyc, done, cyc == 11); end
      if (cyc == 1) begin
        total++; if (row !== 32'h0000_0001) begin bad++; $display("FAIL id_row_t0: got %h exp 00000001", row); end
        total++; if (col !== 32'h0000_0001) begin bad++; $display("FAIL id_col_t0: got %h exp 00000001", col); end
      end
      if (cyc == 4) begin
        total++; if (row[3] !== 8'd0) begin bad++; $display("FAIL id_row3_t3: got %h exp 00", row[3]); end
        total++; if (col[3] !== 8'd4) begin bad++; $display("FAIL id_col3_t3: got %h exp 04", col[3]); end
      end
      if (cyc >= 8 && cyc <= 10) begin
        total++; if ({row, col} !== '0) begin bad++; $display("FAIL id_flush cyc%0d: got %h exp 0", cyc, {row, col}); end
      end
    end
    total++; if (dpcount != 10) begin bad++; $display("FAIL id_dp_count: got %0d exp 10", dpcount); end
    total++; if (acc[2][3] != 12) begin bad++; $display("FAIL id_c23: got %0d exp 12", acc[2][3]); end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        total++; if (acc[i][j] != 4*i + j + 1) begin bad++; $display("FAIL id_c%0d%0d: got %0d exp %0d", i, j, acc[i][j], 4*i + j + 1); end
      end
  endtask

  task automatic test_full_op(input string name, input mat_t ma, input mat_t mb, input bit change);
    a = ma; b = mb;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL %s_ready: got %b exp 1", name, ready); end
    start = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      total++; if (row !== exp_row(ma, cyc - 1)) begin bad++; $display("FAIL %s_row cyc%0d: got %h exp %h", name, cyc, row, exp_row(ma, cyc - 1)); end
      total++; if (col !== exp_col(mb, cyc - 1)) begin bad++; $display("FAIL %s_col cyc%0d: got %h exp %h", name, cyc, col, exp_col(mb, cyc - 1)); end
      total++; if ({dp, busy} !== {2{cyc <= 10}}) begin bad++; $display("FAIL %s_dp_busy cyc%0d: got %b exp %b", name, cyc, {dp, busy}, {2{cyc <= 10}}); end
      total++; if (done !== (cyc == 11)) begin bad++; $display("FAIL %s_done cyc%0d: got %b exp %b", name, cyc, done, cyc == 11); end
      if (change && cyc == 2) begin a = ~ma; b = ~mb; end
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        total++; if (acc[i][j] != exp_c(ma, mb, i, j)) begin bad++; $display("FAIL %s_c%0d%0d: got %0d exp %0d", name, i, j, acc[i][j], exp_c(ma, mb, i, j)); end
      end
  endtask

  task automatic test_extremes;
    mat_t ma, mb;
    for (int r = 0; r < N; r++)
      for (int k = 0; k < N; k++) begin
        ma[r][k] = 8'h80;
        mb[r][k] = 8'h7F;
      end
    test_full_op("ext", ma, mb, 1'b0);
    total++; if (acc[0][0] != -65024) begin bad++; $display("FAIL ext_c00: got %0d exp -65024", acc[0][0]); end
    total++; if (acc[3][3] != -65024) begin bad++; $display("FAIL ext_c33: got %0d exp -65024", acc[3][3]); end
  endtask

  task automatic test_start_held;
    int notready = 0;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL held_ready0: got %b exp 1", ready); end
    start = 1'b1;
    for (int s = 1; s <= 24; s++) begin
      @(negedge clk);
      if (s <= 11 && ready === 1'b0) notready++;
      total++; if (done !== (s == 11 || s == 23)) begin bad++; $display("FAIL held_done s%0d: got %b exp %b", s, done, s == 11 || s == 23); end
      total++; if (ready !== (s == 12 || s == 24)) begin bad++; $display("FAIL held_ready s%0d: got %b exp %b", s, ready, s == 12 || s == 24); end
    end
    start = 1'b0;
    total++; if (notready != 11) begin bad++; $display("FAIL held_gap: got %0d exp 11", notready); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_feed;
    mat_t ma, mb;
    for (int r = 0; r < N; r++)
      for (int k = 0; k < N; k++) begin
        ma[r][k] = 8'(r * 8 + k + 3);
        mb[r][k] = 8'(20 - r * 5 - k);
      end
    a = ma; b = mb;
    start = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    total++; if ({dp, busy} !== 2'b11) begin bad++; $display("FAIL rst_mid_active: got %b exp 11", {dp, busy}); end
    arst = 1'b0;
    #1;
    total++; if ({dp, busy, done} !== 3'b000) begin bad++; $display("FAIL rst_mid_flags: got %b exp 000", {dp, busy, done}); end
    total++; if ({row, col} !== '0) begin bad++; $display("FAIL rst_mid_data: got %h exp 0", {row, col}); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready: got %b exp 1", ready); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_mid_nodone%0d: got %b exp 0", c, done); end
    end
    arst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++; if ({ready, busy, done} !== 3'b100) begin bad++; $display("FAIL rst_post%0d: got %b exp 100", c, {ready, busy, done}); end
    end
    test_full_op("post_rst", ma, mb, 1'b0);
  endtask

  task automatic test_input_change;
    mat_t ma, mb;
    for (int r = 0; r < N; r++)
      for (int k = 0; k < N; k++) begin
        ma[r][k] = 8'(r * 16 + k * 7 - 30);
        mb[r][k] = 8'(k * 13 - r * 9 + 5);
      end
    test_full_op("chg", ma, mb, 1'b1);
  endtask

  initial begin
    test_reset();
    test_identity();
    @(negedge clk);
    test_extremes();
    @(negedge clk);
    test_start_held();
    test_reset_mid_feed();
    @(negedge clk);
    test_input_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
